// File: rtl/uart_pkg.sv
// Shared UART transmitter definitions: FSM encoding, default clocking and the
// clocks-per-bit calculation.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam int unsigned DEF_CLK_FREQ = 50_000_000;
    localparam int unsigned DEF_UART_BPS = 9600;

    function automatic int unsigned baud_cnt_max(input int unsigned clk_freq,
                                                 input int unsigned bps);
        return clk_freq / bps;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..BAUD_CNT_MAX-1 while enabled and strobes bit_end
// on the last count. Held at zero while disabled.
module uart_baud_gen #(
    parameter int unsigned BAUD_CNT_MAX = 5208
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic en,
    output logic bit_end
);

    localparam int unsigned  CW   = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
    localparam logic [CW-1:0] LAST = CW'(BAUD_CNT_MAX - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!en || cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_end = en && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB first, optional parity, 1-2 stop bits,
// with a one-byte hold register so a byte arriving mid-frame follows with no gap.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = DEF_CLK_FREQ,
    parameter int unsigned UART_BPS   = DEF_UART_BPS,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [7:0] pi_data,
    input  logic       pi_flag,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       overrun
);

    localparam int unsigned BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, UART_BPS);
    localparam logic        PAR_ODD      = (PARITY_ODD != 0);
    localparam logic        STOP_LAST    = (STOP_BITS == 2);

    tx_state_e  state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       stop_cnt_q, stop_cnt_d;
    logic       parity_q, parity_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_vld_q, hold_vld_d;
    logic       tx_q, tx_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       ovr_q, ovr_d;

    logic       bit_end;
    logic       frame_end;
    logic       load;
    logic [7:0] load_byte;

    uart_baud_gen #(
        .BAUD_CNT_MAX(BAUD_CNT_MAX)
    ) u_baud (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .en       (state_q != IDLE),
        .bit_end  (bit_end)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        parity_d   = parity_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        done_d     = 1'b0;
        ovr_d      = 1'b0;
        load       = 1'b0;
        load_byte  = pi_data;
        frame_end  = (state_q == STOP) && bit_end && (stop_cnt_q == STOP_LAST);

        unique case (state_q)
            IDLE: begin
                if (pi_flag) load = 1'b1;
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (frame_end) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                    // Held byte goes first; a same-cycle strobe then takes the freed slot.
                    if (hold_vld_q) begin
                        load       = 1'b1;
                        load_byte  = hold_q;
                        hold_vld_d = pi_flag;
                        if (pi_flag) hold_d = pi_data;
                    end else if (pi_flag) begin
                        load = 1'b1;
                    end
                end else if (bit_end) begin
                    stop_cnt_d = stop_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pi_flag && state_q != IDLE && !frame_end) begin
            if (!hold_vld_q) begin
                hold_d     = pi_data;
                hold_vld_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end

        if (load) begin
            state_d    = START;
            shift_d    = load_byte;
            parity_d   = (^load_byte) ^ PAR_ODD;
            bit_cnt_d  = 3'd0;
            stop_cnt_d = 1'b0;
        end

        unique case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_q[0];
            PARITY:  tx_d = parity_q;
            default: tx_d = 1'b1;
        endcase

        busy_d = (state_q != IDLE) || hold_vld_q;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            parity_q   <= 1'b0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            parity_q   <= parity_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovr_q      <= ovr_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;
    assign overrun = ovr_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: three framing configurations at 16 clocks/bit,
// a timing-level reference model feeding per-DUT queues, line-decoding monitors.
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int B  = 16;
    localparam int ND = 3;

    typedef struct {
        logic [7:0] b;
        int         end_e;
    } exp_t;

    logic              sys_clk;
    logic              sys_rst_n;
    logic [7:0]        pd [ND];
    logic [ND-1:0]     pf;
    logic [ND-1:0]     tx_w, busy_w, done_w, ovr_w;

    int   edge_cnt = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sb [ND][$];
    int   cur_end [ND];
    bit   hold_v [ND];
    int   exp_ovr [ND];
    int   ovr_cnt [ND];

    uart_tx #(.CLK_FREQ(160), .UART_BPS(10), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pi_data(pd[0]), .pi_flag(pf[0]),
        .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]), .overrun(ovr_w[0]));
    uart_tx #(.CLK_FREQ(160), .UART_BPS(10), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut1 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pi_data(pd[1]), .pi_flag(pf[1]),
        .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]), .overrun(ovr_w[1]));
    uart_tx #(.CLK_FREQ(160), .UART_BPS(10), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut2 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pi_data(pd[2]), .pi_flag(pf[2]),
        .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]), .overrun(ovr_w[2]));

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) edge_cnt <= edge_cnt + 1;

    always @(negedge sys_clk) begin
        for (int d = 0; d < ND; d++) if (ovr_w[d] === 1'b1) ovr_cnt[d] <= ovr_cnt[d] + 1;
    end

    function automatic bit par_en(input int d);  return d != 0; endfunction
    function automatic bit par_odd(input int d); return d == 2; endfunction
    function automatic int nbits(input int d);   return 9 + int'(par_en(d)) + ((d == 2) ? 2 : 1); endfunction
    function automatic int flen(input int d);    return nbits(d) * B; endfunction

    // Line image of a frame, bit 0 = start bit, unused upper positions zero.
    function automatic logic [11:0] exp_frame(input int d, input logic [7:0] b);
        logic [11:0] f;
        f = '1;
        f[0] = 1'b0;
        f[8:1] = b;
        if (par_en(d)) f[9] = (($countones(b) % 2) == 1) != par_odd(d);
        for (int k = nbits(d); k < 12; k++) f[k] = 1'b0;
        return f;
    endfunction

    task automatic check(input string nm, input int d, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s dut%0d: got %0h expected %0h (edge %0d)", nm, d, act, req, edge_cnt);
        end
    endtask

    // A held byte starts exactly when the frame ahead of it ends.
    task automatic advance(input int d, input int t);
        while (hold_v[d] && t > cur_end[d]) begin
            cur_end[d] += flen(d);
            hold_v[d] = 1'b0;
        end
    endtask

    task automatic strobe(input int d, input logic [7:0] b);
        int   t;
        bit   ok;
        bit   ovr_exp;
        exp_t e;
        ok = 1'b0;
        t  = 0;
        while (!ok) begin
            @(negedge sys_clk);
            t = edge_cnt + 1;
            advance(d, t);
            ok = !(t == cur_end[d] && hold_v[d]);
        end
        ovr_exp = 1'b0;
        e.b = b;
        if (t >= cur_end[d]) begin
            cur_end[d] = t + flen(d);
            e.end_e = cur_end[d];
            sb[d].push_back(e);
        end else if (!hold_v[d]) begin
            hold_v[d] = 1'b1;
            e.end_e = cur_end[d] + flen(d);
            sb[d].push_back(e);
        end else begin
            ovr_exp = 1'b1;
            exp_ovr[d]++;
        end
        pd[d] = b;
        pf[d] = 1'b1;
        @(negedge sys_clk);
        pf[d] = 1'b0;
        pd[d] = 8'($urandom);
        check("overrun_pulse", d, 32'(ovr_w[d]), 32'(ovr_exp));
    endtask

    task automatic wait_until(input int e);
        while (edge_cnt < e) @(negedge sys_clk);
    endtask

    task automatic wait_idle(input int d);
        int lim;
        lim = 3 * flen(d) + 20;
        advance(d, edge_cnt);
        while (lim > 0 && !(sb[d].size() == 0 && !hold_v[d] && edge_cnt > cur_end[d] + 1)) begin
            @(negedge sys_clk);
            advance(d, edge_cnt);
            lim--;
        end
        if (lim == 0) check("idle_timeout", d, 32'(sb[d].size()), 32'd0);
    endtask

    for (genvar g = 0; g < ND; g++) begin : g_mon
        initial begin
            int          cyc;
            logic [11:0] bits;
            exp_t        e;
            cyc = -1;
            bits = '0;
            forever begin
                @(negedge sys_clk);
                if (sys_rst_n !== 1'b1) begin
                    cyc = -1;
                    continue;
                end
                if (cyc < 0) begin
                    if (tx_w[g] === 1'b0) begin
                        cyc = 0;
                        bits = '0;
                    end
                end else begin
                    cyc++;
                end
                if (done_w[g] === 1'b1 && cyc != nbits(g) * B - 1) begin
                    total++;
                    bad++;
                    $display("FAIL stray_tx_done dut%0d: got 1 expected 0 (edge %0d)", g, edge_cnt);
                end
                if (cyc >= 0) begin
                    if (cyc % B == B / 2) bits[cyc / B] = tx_w[g];
                    if (cyc == nbits(g) * B - 1) begin
                        if (sb[g].size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_frame dut%0d: got %0h expected none", g, bits);
                        end else begin
                            e = sb[g].pop_front();
                            check("frame_bits", g, 32'(bits), 32'(exp_frame(g, e.b)));
                            check("done_edge", g, (done_w[g] === 1'b1) ? edge_cnt : 0, e.end_e);
                        end
                        cyc = -1;
                    end
                end
            end
        end
    end

    initial begin
        int  n;
        int  end2;
        bit  flag;
        for (int d = 0; d < ND; d++) begin
            pd[d] = 8'h00;
            cur_end[d] = -1;
            hold_v[d] = 1'b0;
            exp_ovr[d] = 0;
            ovr_cnt[d] = 0;
        end
        pf = '0;
        sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        for (int d = 0; d < ND; d++) begin
            check("reset_tx", d, 32'(tx_w[d]), 32'd1);
            check("reset_busy", d, 32'(busy_w[d]), 32'd0);
            check("reset_done", d, 32'(done_w[d]), 32'd0);
            check("reset_overrun", d, 32'(ovr_w[d]), 32'd0);
        end
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        // 0x55, latency and busy release
        strobe(0, 8'h55);
        n = edge_cnt;
        check("tx_before_start", 0, 32'(tx_w[0]), 32'd1);
        @(negedge sys_clk);
        check("tx_start_latency", 0, 32'(tx_w[0]), 32'd0);
        check("busy_rise", 0, 32'(busy_w[0]), 32'd1);
        wait_until(n + 10 * B);
        check("busy_on_done", 0, 32'(busy_w[0]), 32'd1);
        @(negedge sys_clk);
        check("busy_fall", 0, 32'(busy_w[0]), 32'd0);
        wait_idle(0);

        // 0xA5 then 0x3C mid-frame: held, sent back to back
        strobe(0, 8'hA5);
        repeat (5 * B) @(negedge sys_clk);
        strobe(0, 8'h3C);
        end2 = cur_end[0] + flen(0);
        flag = 1'b1;
        while (edge_cnt < end2) begin
            @(negedge sys_clk);
            if (busy_w[0] !== 1'b1) flag = 1'b0;
        end
        check("busy_through_pair", 0, 32'(flag), 32'd1);
        wait_idle(0);

        // three bytes in one frame: third dropped
        strobe(0, 8'h11);
        repeat (2 * B) @(negedge sys_clk);
        strobe(0, 8'h22);
        repeat (B) @(negedge sys_clk);
        strobe(0, 8'h33);
        wait_idle(0);

        // strobe on the tx_done edge with hold empty chains immediately
        strobe(0, 8'hC3);
        wait_until(cur_end[0] - 2);
        strobe(0, 8'h81);
        wait_idle(0);

        // parity configurations
        strobe(1, 8'h07);
        strobe(2, 8'h07);
        wait_idle(1);
        wait_idle(2);

        // reset during data bit 3 with a byte held
        strobe(0, 8'hF0);
        n = cur_end[0] - flen(0);
        strobe(0, 8'h99);
        wait_until(n + 1 + 4 * B + B / 2);
        sys_rst_n = 1'b0;
        #1;
        check("rst_tx_async", 0, 32'(tx_w[0]), 32'd1);
        check("rst_busy_async", 0, 32'(busy_w[0]), 32'd0);
        sb[0].delete();
        cur_end[0] = -1;
        hold_v[0] = 1'b0;
        @(negedge sys_clk);
        pd[0] = 8'hAA;
        pf[0] = 1'b1;
        @(negedge sys_clk);
        pf[0] = 1'b0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        flag = 1'b1;
        repeat (3 * flen(0)) begin
            @(negedge sys_clk);
            if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) flag = 1'b0;
        end
        check("quiet_after_reset", 0, 32'(flag), 32'd1);

        // randomized traffic across all configurations
        for (int i = 0; i < 60; i++) begin
            int d;
            d = int'($urandom_range(0, ND - 1));
            repeat ($urandom_range(0, 2 * flen(d))) @(negedge sys_clk);
            strobe(d, 8'($urandom));
        end
        for (int d = 0; d < ND; d++) wait_idle(d);
        repeat (4) @(negedge sys_clk);
        for (int d = 0; d < ND; d++) begin
            check("overrun_count", d, 32'(ovr_cnt[d]), 32'(exp_ovr[d]));
            check("frames_left", d, 32'(sb[d].size()), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
